// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seg7_scan_mux display driver.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef struct packed {
        logic       dp;
        logic [3:0] nib;
    } digit_t;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/decobin2seg.sv
// Hex nibble to common-anode 7-segment decoder (active-low outputs, dp in bit 7).
module decobin2seg
    import seg7_pkg::*;
(
    input  logic [3:0] entrada,
    input  logic       dp,
    output logic [7:0] saida
);

    logic [6:0] lit;

    // lit is active-high, bit 0 = segment a ... bit 6 = segment g
    always_comb begin
        lit = 7'h00;
        case (entrada)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            4'hF: lit = 7'h71;
            default: lit = 7'h00;
        endcase
    end

    always_comb begin
        saida                = SEG_OFF;
        saida[SEG_G:SEG_A]   = ~lit;
        saida[SEG_DP]        = ~dp;
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed common-anode 7-segment scanner with a pending/shadow double buffer.
// Define SEG7_SCAN_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int PW = cnt_width(SCAN_DIV);
    localparam int IW = cnt_width(N_DIGITS);
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);

    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [4*N_DIGITS-1:0]   shad_val_q, shad_val_d;
    logic [N_DIGITS-1:0]     shad_dp_q, shad_dp_d;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick;
    logic                    wrap;
    digit_t                  digits [N_DIGITS];
    digit_t                  sel_digit;
    logic [7:0]              dec_seg;
    logic                    blank_sel;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign digits[gi].nib = shad_val_q[4*gi +: 4];
            assign digits[gi].dp  = shad_dp_q[gi];
        end
    endgenerate

    assign tick      = (pcnt_q == PCNT_LAST);
    assign wrap      = tick && (idx_q == IDX_LAST);
    assign sel_digit = digits[idx_q];

    // Scan counters and the frame-boundary double-buffer transfer
    always_comb begin
        pcnt_d       = tick ? '0 : pcnt_q + 1'b1;
        idx_d        = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        shad_val_d   = shad_val_q;
        shad_dp_d    = shad_dp_q;

        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp;
            pend_valid_d = 1'b1;
        end

        if (wrap) begin
            pend_valid_d = 1'b0;
            if (load) begin
                shad_val_d = value;
                shad_dp_d  = dp;
            end else if (pend_valid_q) begin
                shad_val_d = pend_val_q;
                shad_dp_d  = pend_dp_q;
            end
        end

        frame_done_d = wrap;
    end

    decobin2seg u_dec (
        .entrada (sel_digit.nib),
        .dp      (sel_digit.dp),
        .saida   (dec_seg)
    );

`ifdef SEG7_SCAN_BLANK_EN
    logic [N_DIGITS-1:0] zero_from;
    logic                zero_acc;

    // zero_from[i]: nibbles i..N_DIGITS-1 are all zero
    always_comb begin
        zero_from = '0;
        zero_acc  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_acc     = zero_acc && (digits[i].nib == 4'h0);
            zero_from[i] = zero_acc;
        end
    end

    assign blank_sel = (idx_q != '0) && zero_from[idx_q] && !sel_digit.dp;
`else
    assign blank_sel = 1'b0;
`endif

    always_comb begin
        an_d  = ~(AN_ONE << idx_q);
        seg_d = blank_sel ? SEG_OFF : dec_seg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            shad_val_q   <= '0;
            shad_dp_q    <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            shad_val_q   <= shad_val_d;
            shad_dp_q    <= shad_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux with N_DIGITS=4, SCAN_DIV=4.
module tb_seg7_scan_mux;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int FRAME = N * D;

`ifdef SEG7_SCAN_BLANK_EN
    localparam logic [7:0] Z = 8'hFF;
`else
    localparam logic [7:0] Z = 8'hC0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_mux #(.N_DIGITS(N), .SCAN_DIV(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    int checks = 0;
    int failures = 0;

    // reference model: k = edges since reset release, plus the two buffers
    logic [6:0]  font [16];
    int          k;
    logic [15:0] m_sh_v, m_pd_v;
    logic [3:0]  m_sh_dp, m_pd_dp;
    bit          m_pd_ok;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
    logic        exp_fd;

    typedef struct {
        logic [15:0]     v;
        logic [3:0]      m;
        logic [3:0][7:0] e;
    } vec_t;
    vec_t tbl [5];

    function automatic logic [7:0] ref_seg(logic [15:0] v, logic [3:0] m, int d);
        logic [3:0] nib;
        logic       blank;
        nib   = 4'((v >> (4 * d)) & 16'hF);
        blank = 1'b0;
`ifdef SEG7_SCAN_BLANK_EN
        blank = (d > 0) && ((v >> (4 * d)) == 16'h0) && !m[d];
`endif
        return blank ? 8'hFF : ~{m[d], font[nib]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        int d;
        @(posedge clk);
        if (!reset) begin
            k = 0;
            m_sh_v = '0; m_sh_dp = '0; m_pd_v = '0; m_pd_dp = '0; m_pd_ok = 0;
            exp_an = 4'hF; exp_seg = 8'hFF; exp_fd = 1'b0;
        end else begin
            d       = (k / D) % N;
            exp_an  = ~(4'b0001 << d);
            exp_seg = ref_seg(m_sh_v, m_sh_dp, d);
            exp_fd  = ((k % FRAME) == FRAME - 1);
            if (load) begin
                m_pd_v = value; m_pd_dp = dp; m_pd_ok = 1;
            end
            if ((k % FRAME) == FRAME - 1) begin
                if (load) begin
                    m_sh_v = value; m_sh_dp = dp;
                end else if (m_pd_ok) begin
                    m_sh_v = m_pd_v; m_sh_dp = m_pd_dp;
                end
                m_pd_ok = 0;
            end
            k++;
        end
        #1;
        chk("model_an", 32'(an), 32'(exp_an));
        chk("model_seg", 32'(seg), 32'(exp_seg));
        chk("model_frame_done", 32'(frame_done), 32'(exp_fd));
    endtask

    task automatic run_until(input int phase);
        for (int i = 0; i < FRAME && (k % FRAME) != phase; i++) tick();
    endtask

    initial begin
        int cnt_a, cnt_b;
        font[0] = 7'h3F; font[1] = 7'h06; font[2] = 7'h5B; font[3] = 7'h4F;
        font[4] = 7'h66; font[5] = 7'h6D; font[6] = 7'h7D; font[7] = 7'h07;
        font[8] = 7'h7F; font[9] = 7'h6F; font[10] = 7'h77; font[11] = 7'h7C;
        font[12] = 7'h39; font[13] = 7'h5E; font[14] = 7'h79; font[15] = 7'h71;
        k = 0;

        tbl[0] = '{16'h12AF, 4'b0100, {8'hF9, 8'h24, 8'h88, 8'h8E}};
        tbl[1] = '{16'h0070, 4'b0000, {Z, Z, 8'hF8, 8'hC0}};
        tbl[2] = '{16'h8E3D, 4'b1111, {8'h00, 8'h06, 8'h30, 8'h21}};
        tbl[3] = '{16'h0000, 4'b0000, {Z, Z, Z, 8'hC0}};
        tbl[4] = '{16'h0509, 4'b0000, {Z, 8'h92, 8'hC0, 8'h90}};

        // reset state and startup scan cadence
        for (int i = 0; i < 3; i++) tick();
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'hFF);
        chk("reset_frame_done", 32'(frame_done), 32'h0);
        reset = 1'b1;
        tick();
        chk("first_an", 32'(an), 32'hE);
        chk("first_seg", 32'(seg), 32'hC0);
        cnt_a = 0; cnt_b = (an == 4'hE) ? 1 : 0;
        for (int i = 1; i < 48; i++) begin
            tick();
            if (frame_done) cnt_a++;
            if (an == 4'hE) cnt_b++;
        end
        chk("frame_done_count", 32'(cnt_a), 32'd3);
        chk("digit0_slot_cycles", 32'(cnt_b), 32'd12);

        // table: load exactly on the boundary cycle, then read one full frame
        for (int t = 0; t < 5; t++) begin
            run_until(FRAME - 1);
            load = 1'b1; value = tbl[t].v; dp = tbl[t].m;
            tick();
            load = 1'b0;
            for (int j = 0; j < FRAME; j++) begin
                tick();
                chk($sformatf("tbl%0d_digit%0d_seg", t, j / D), 32'(seg), 32'(tbl[t].e[j / D]));
            end
        end

        // two loads within one frame: last wins
        run_until(5);
        load = 1'b1; value = 16'h1111; dp = 4'h0;
        tick();
        load = 1'b0;
        run_until(9);
        load = 1'b1; value = 16'h2222; dp = 4'h0;
        tick();
        load = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (seg == 8'hF9) cnt_a++;
            if (seg == 8'hA4) cnt_b++;
        end
        chk("two_loads_first_never_shown", 32'(cnt_a), 32'd0);
        chk("two_loads_second_shown", 32'(cnt_b >= FRAME), 32'd1);

        // reset mid-frame discards a pending load
        run_until(6);
        load = 1'b1; value = 16'h5555; dp = 4'h0;
        tick();
        load = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("midreset_an", 32'(an), 32'hF);
        chk("midreset_seg", 32'(seg), 32'hFF);
        chk("midreset_frame_done", 32'(frame_done), 32'h0);
        reset = 1'b1;
        tick();
        chk("midreset_release_an", 32'(an), 32'hE);
        chk("midreset_release_seg", 32'(seg), 32'hC0);
        cnt_a = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (seg == 8'h92) cnt_a++;
        end
        chk("midreset_pending_dropped", 32'(cnt_a), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 1000; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            dp    = 4'($urandom);
            reset = ($urandom_range(0, 149) != 0);
            tick();
        end
        reset = 1'b1; load = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed driver for a bank of common-anode 7-segment digits. It sits directly downstream of the hex counter stage, which produces one 4-bit nibble plus a decimal-point flag per digit. It latches a multi-digit value with a load strobe and holds it in a shadow register so a frame is never torn. It then scans the digits one at a time through a single shared segment decoder.

## Interface
- N_DIGITS, 4, number of digits scanned (2..8)
- SCAN_DIV, 50000, clk cycles each digit stays enabled (≥2)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- value  in  4*N_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 least significant
- dp  in  N_DIGITS  decimal-point request per digit, 1 = lit
- load  in  1  single-cycle strobe; captures value/dp into the pending buffer
- seg  out  8  segments a..g in bits 0..6, dp in bit 7; active-low (0 = lit)
- an  out  N_DIGITS  digit enables, one-hot active-low
- frame_done  out  1  one-cycle pulse each time digit N_DIGITS-1 finishes

## Operation
- Pending buffer (value, dp, pend_valid): written on load; a later load before the frame boundary overwrites it (last wins).
- Shadow buffer: the only source for display. Updated only at the frame boundary (tick while idx = N_DIGITS-1):
  - if load is high that cycle, the incoming value goes straight to shadow;
  - else if pend_valid is set, pending goes to shadow;
  - pend_valid clears in either case.
- Prescaler pcnt counts 0..SCAN_DIV-1 and wraps. tick = (pcnt == SCAN_DIV-1).
- Digit index idx advances on tick and wraps from N_DIGITS-1 to 0. frame_done is asserted on the cycle following that wrap tick.
- Output stage, registered from idx and shadow:
  - an = ~(1 << idx);
  - seg = decode(shadow nibble[idx], shadow dp[idx]).
- No state machine beyond the prescaler and idx counters. The buffers form a two-stage handshake-free double buffer.

## Timing
- Reset values, with reset low at a rising edge:
  - pcnt = 0, idx = 0;
  - shadow and pending all zero, pend_valid = 0;
  - an = all ones (all off), seg = 8'hFF, frame_done = 0.
- Output latency: an/seg reflect idx and shadow one clk after they change. The first cycle after reset release shows digit 0 with the segment pattern for 0.
- Each digit is enabled for exactly SCAN_DIV cycles. A frame is N_DIGITS*SCAN_DIV cycles.
- load to display: the value appears on the first digit-0 slot after the next frame boundary. Worst case is one full frame plus 1 cycle.
- Reset asserted mid-frame: everything returns to reset values on that edge. Any pending load is discarded.
- load is ignored while reset is low.

## Configuration
- SEG7_SCAN_BLANK_EN defined: leading-zero blanking is enabled.
  - Digit i > 0 is blanked (seg = 8'hFF, an still enabled) when shadow nibbles i..N_DIGITS-1 are all zero and dp[i] is 0.
  - Digit 0 is never blanked.
- SEG7_SCAN_BLANK_EN undefined: every digit always shows its nibble, including leading zeros.

## Structure
- Shared package seg7_pkg holds:
  - SEG_OFF = 8'hFF;
  - segment bit-position constants;
  - the clog2-based width function for pcnt and idx.
- One sub-module: the existing decobin2seg instance as the single shared decoder (entrada = selected nibble, dp = selected dp, saida = pre-blank segments).
- Blanking mux, prescaler, index counter and buffers stay in the top module.

## Test plan
All scenarios use N_DIGITS=4 and SCAN_DIV=4.
- Reset release → an = 4'b1110 and seg = decode(0) on the first cycle; each digit is held 4 cycles; frame_done pulses once every 16 cycles.
- load value=16'h12AF, dp=4'b0100 once → after the next frame boundary, digits 0..3 show F, A, 2, 1, with the dp bit low only on digit 2.
- Two loads in one frame (16'h1111 then 16'h2222) → only 2222 is ever displayed; 1111 never appears on seg.
- load on the exact boundary cycle → that value is shown from the very next digit-0 slot, with no extra frame of delay.
- SEG7_SCAN_BLANK_EN defined, value=16'h0070 → digits 3 and 2 give seg = 8'hFF, digit 1 shows 7, digit 0 shows 0. With the macro undefined, all four digits are lit.
- reset driven low mid-frame with a pending load → next cycle an = 4'b1111 and seg = 8'hFF; after release, digit 0 shows 0 and the pending value is never shown.
